// File: rtl/sha_ctrl_pkg.sv
// Shared constants and state encoding for the double-SHA nonce scheduler.
// Latency: n/a. Backpressure: n/a.
// Holds no logic, only types and constants.
package sha_ctrl_pkg;

    localparam int MSG_W    = 440;
    localparam int LEN_W    = 64;
    localparam int DIGEST_W = 256;
    localparam int NONCE_W  = 32;

    typedef logic [3:0] sha_sched_state_t;

    localparam sha_sched_state_t ST_IDLE   = 4'd0;
    localparam sha_sched_state_t ST_ISSUE1 = 4'd1;
    localparam sha_sched_state_t ST_DRAIN1 = 4'd2;
    localparam sha_sched_state_t ST_WAIT1  = 4'd3;
    localparam sha_sched_state_t ST_ISSUE2 = 4'd4;
    localparam sha_sched_state_t ST_DRAIN2 = 4'd5;
    localparam sha_sched_state_t ST_WAIT2  = 4'd6;
    localparam sha_sched_state_t ST_CHECK  = 4'd7;
    localparam sha_sched_state_t ST_FINISH = 4'd8;

endpackage

// File: rtl/sha_pass_timer.sv
// Per-pass watchdog: counts enabled cycles, flags expiry when the count equals TIMEOUT.
// Latency: expired is combinational from the registered count.
// Backpressure: none; the count holds at TIMEOUT until cleared.
module sha_pass_timer #(
    parameter int TIMEOUT = 511
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    logic [CNT_W-1:0] count;

    assign expired = en && (count == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Sweeps nonces through a shared SHA-256 core twice per nonce and stops on digest < target.
// Latency: 2 x core latency + 7 cycles per nonce.
// Backpressure: waits on the core's completion level, bounded by the pass timer.
module sha_nonce_scheduler
    import sha_ctrl_pkg::*;
#(
    parameter int PREFIX_W = 352,
    parameter int TIMEOUT  = 511
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PREFIX_W-1:0]   prefix,
    input  logic [NONCE_W-1:0]    nonce_start,
    input  logic [NONCE_W-1:0]    nonce_end,
    input  logic [DIGEST_W-1:0]   target,
    output logic [MSG_W-1:0]      sha_msg,
    output logic [LEN_W-1:0]      sha_len,
    output logic                  sha_begin,
    input  logic                  sha_complete,
    input  logic [DIGEST_W-1:0]   sha_digest,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [NONCE_W-1:0]    golden_nonce,
    output logic [DIGEST_W-1:0]   golden_hash,
    output logic [NONCE_W-1:0]    cur_nonce,
    output logic                  timeout_err
);

    localparam logic [LEN_W-1:0] LEN_PASS1 = LEN_W'(PREFIX_W + NONCE_W);
    localparam logic [LEN_W-1:0] LEN_PASS2 = LEN_W'(DIGEST_W);

    sha_sched_state_t      state;
    logic [PREFIX_W-1:0]   prefix_q;
    logic [NONCE_W-1:0]    end_q;
    logic [DIGEST_W-1:0]   target_q;
    logic [DIGEST_W-1:0]   digest_q;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_expired;

    assign sha_begin = (state == ST_ISSUE1) || (state == ST_ISSUE2);
    assign busy      = (state != ST_IDLE) && (state != ST_FINISH);
    assign tmr_clr   = sha_begin;
    assign tmr_en    = (state == ST_DRAIN1) || (state == ST_WAIT1) ||
                       (state == ST_DRAIN2) || (state == ST_WAIT2);

    sha_pass_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    function automatic logic [MSG_W-1:0] pack_pass1(input logic [PREFIX_W-1:0] p,
                                                    input logic [NONCE_W-1:0]  n);
        pack_pass1 = MSG_W'({p, n});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            prefix_q     <= '0;
            end_q        <= '0;
            target_q     <= '0;
            digest_q     <= '0;
            sha_msg      <= '0;
            sha_len      <= '0;
            done         <= 1'b0;
            found        <= 1'b0;
            golden_nonce <= '0;
            golden_hash  <= '0;
            cur_nonce    <= '0;
            timeout_err  <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            // Any in-flight pass is abandoned; DRAIN on the next sweep hides its completion.
            state <= ST_IDLE;
            done  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        prefix_q    <= prefix;
                        end_q       <= nonce_end;
                        target_q    <= target;
                        cur_nonce   <= nonce_start;
                        sha_msg     <= pack_pass1(prefix, nonce_start);
                        sha_len     <= LEN_PASS1;
                        done        <= 1'b0;
                        found       <= 1'b0;
                        timeout_err <= 1'b0;
                        state       <= ST_ISSUE1;
                    end
                end
                ST_ISSUE1: state <= ST_DRAIN1;
                ST_ISSUE2: state <= ST_DRAIN2;
                ST_DRAIN1, ST_DRAIN2: begin
                    if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end else if (!sha_complete) begin
                        state <= (state == ST_DRAIN1) ? ST_WAIT1 : ST_WAIT2;
                    end
                end
                ST_WAIT1: begin
                    if (sha_complete) begin
                        sha_msg <= MSG_W'(sha_digest);
                        sha_len <= LEN_PASS2;
                        state   <= ST_ISSUE2;
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end
                ST_WAIT2: begin
                    if (sha_complete) begin
                        digest_q <= sha_digest;
                        state    <= ST_CHECK;
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end
                ST_CHECK: begin
                    if (digest_q < target_q) begin
                        found        <= 1'b1;
                        golden_nonce <= cur_nonce;
                        golden_hash  <= digest_q;
                        done         <= 1'b1;
                        state        <= ST_FINISH;
                    end else if (cur_nonce == end_q) begin
                        done  <= 1'b1;
                        found <= 1'b0;
                        state <= ST_FINISH;
                    end else begin
                        cur_nonce <= cur_nonce + 1'b1;
                        sha_msg   <= pack_pass1(prefix_q, cur_nonce + 1'b1);
                        sha_len   <= LEN_PASS1;
                        state     <= ST_ISSUE1;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler using a stub SHA core with programmable latency/digests.
// Stub keeps sha_complete high for two cycles after a new begin, like a slow core.
module tb_sha_nonce_scheduler;

    localparam int TIMEOUT = 511;
    localparam logic [223:0] P1PAT = {7{32'hC0DE_F00D}};
    localparam logic [255:0] DEF2  = {{255{1'b1}}, 1'b0};
    localparam logic [351:0] PA    = {11{32'h1234_5678}};
    localparam logic [351:0] PB    = {11{32'hDEAD_BEEF}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [351:0] prefix = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic [439:0] sha_msg;
    logic [63:0]  sha_len;
    logic         sha_begin;
    logic         sha_complete;
    logic [255:0] sha_digest;
    logic         busy, done, found, timeout_err;
    logic [31:0]  golden_nonce, cur_nonce;
    logic [255:0] golden_hash;

    int n_tests = 0;
    int n_fail  = 0;

    sha_nonce_scheduler #(.PREFIX_W(352), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prefix(prefix),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .sha_msg(sha_msg), .sha_len(sha_len), .sha_begin(sha_begin),
        .sha_complete(sha_complete), .sha_digest(sha_digest), .busy(busy),
        .done(done), .found(found), .golden_nonce(golden_nonce),
        .golden_hash(golden_hash), .cur_nonce(cur_nonce), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Stub SHA core
    int           lat = 70;
    bit           hang = 1'b0;
    bit           hit_en = 1'b0;
    logic [31:0]  hit_nonce = '0;
    logic [255:0] hit_dig = '0;
    int           n_begin = 0;
    int           n_begin1 = 0;
    logic [31:0]  n1_log [0:63];
    logic [439:0] last_msg1 = '0, last_msg2 = '0;
    logic [63:0]  last_len1 = '0, last_len2 = '0;
    int           st_cnt = 0;
    bit           st_run = 1'b0;
    logic [439:0] st_msg = '0;
    logic [63:0]  st_len = '0;

    always @(posedge clk) begin
        if (rst) begin
            sha_complete <= 1'b0;
            sha_digest   <= '0;
            st_run       <= 1'b0;
            st_cnt       <= 0;
        end else if (sha_begin) begin
            st_run  <= 1'b1;
            st_cnt  <= 0;
            st_msg  <= sha_msg;
            st_len  <= sha_len;
            n_begin <= n_begin + 1;
            if (sha_len == 64'd256) begin
                last_msg2 <= sha_msg;
                last_len2 <= sha_len;
            end else begin
                n1_log[n_begin1[5:0]] <= sha_msg[31:0];
                n_begin1  <= n_begin1 + 1;
                last_msg1 <= sha_msg;
                last_len1 <= sha_len;
            end
        end else if (st_run) begin
            st_cnt <= st_cnt + 1;
            if (st_cnt == 1) sha_complete <= 1'b0;
            if (!hang && st_cnt == lat) begin
                sha_complete <= 1'b1;
                st_run       <= 1'b0;
                if (st_len == 64'd256)
                    sha_digest <= (hit_en && st_msg[31:0] == hit_nonce) ? hit_dig : DEF2;
                else
                    sha_digest <= {P1PAT, st_msg[31:0]};
            end
        end
    end

    function automatic logic [439:0] pk(input logic [351:0] p, input logic [31:0] n);
        pk = '0;
        pk[383:0] = {p, n};
    endfunction

    task automatic do_start(input logic [351:0] p, input logic [31:0] ns,
                            input logic [31:0] ne, input logic [255:0] tg);
        @(negedge clk);
        prefix = p; nonce_start = ns; nonce_end = ne; target = tg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic wait_begins(input int base, input int cnt);
        int cyc = 0;
        while ((n_begin - base) < cnt && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if ((n_begin - base) < cnt) begin
            n_fail++;
            $display("FAIL wait_begins: saw %0d begins, required %0d", n_begin - base, cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (sha_begin !== 1'b0) begin n_fail++; $display("FAIL reset_begin: got %b want 0", sha_begin); end
        n_tests++; if (sha_msg !== '0) begin n_fail++; $display("FAIL reset_msg: got %h want 0", sha_msg); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
    endtask

    task automatic test_single_nonce();
        int b0 = n_begin;
        do_start(PA, 32'd5, 32'd5, {256{1'b1}});
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_run: got %b want 1", busy); end
        wait_done(5000);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL t1_found: got %b want 1", found); end
        n_tests++; if (golden_nonce !== 32'd5) begin n_fail++; $display("FAIL t1_gnonce: got %h want 5", golden_nonce); end
        n_tests++; if (n_begin - b0 !== 2) begin n_fail++; $display("FAIL t1_begins: got %0d want 2", n_begin - b0); end
        n_tests++; if (last_len1 !== 64'd384) begin n_fail++; $display("FAIL t1_len1: got %0d want 384", last_len1); end
        n_tests++; if (last_len2 !== 64'd256) begin n_fail++; $display("FAIL t1_len2: got %0d want 256", last_len2); end
        n_tests++; if (last_msg1 !== pk(PA, 32'd5)) begin n_fail++; $display("FAIL t1_msg1: got %h", last_msg1); end
        n_tests++; if (last_msg2 !== {184'd0, P1PAT, 32'd5}) begin n_fail++; $display("FAIL t1_msg2: got %h", last_msg2); end
        n_tests++; if (golden_hash !== DEF2) begin n_fail++; $display("FAIL t1_ghash: got %h want %h", golden_hash, DEF2); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy: got %b want 0", busy); end
    endtask

    task automatic test_hit_mid_range();
        int b0 = n_begin;
        hit_en = 1'b1; hit_nonce = 32'd7; hit_dig = 256'h10;
        do_start(PA, 32'd3, 32'd10, 256'h11);
        wait_done(5000);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL t2_found: got %b want 1", found); end
        n_tests++; if (golden_nonce !== 32'd7) begin n_fail++; $display("FAIL t2_gnonce: got %h want 7", golden_nonce); end
        n_tests++; if (n_begin - b0 !== 10) begin n_fail++; $display("FAIL t2_begins: got %0d want 10", n_begin - b0); end
        n_tests++; if (golden_hash !== 256'h10) begin n_fail++; $display("FAIL t2_ghash: got %h want 10", golden_hash); end
        hit_en = 1'b0;
    endtask

    task automatic test_wrap_no_hit();
        int b1 = n_begin1;
        do_start(PB, 32'hFFFF_FFFE, 32'h0000_0001, '0);
        wait_done(5000);
        n_tests++; if (n_begin1 - b1 !== 4) begin n_fail++; $display("FAIL t3_nonces: got %0d want 4", n_begin1 - b1); end
        n_tests++; if (n1_log[b1 % 64] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL t3_first: got %h want fffffffe", n1_log[b1 % 64]); end
        n_tests++; if (n1_log[(b1 + 2) % 64] !== 32'h0) begin n_fail++; $display("FAIL t3_wrap: got %h want 0", n1_log[(b1 + 2) % 64]); end
        n_tests++; if (cur_nonce !== 32'h1) begin n_fail++; $display("FAIL t3_cur: got %h want 1", cur_nonce); end
        n_tests++; if (found !== 1'b0) begin n_fail++; $display("FAIL t3_found: got %b want 0", found); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t3_done: got %b want 1", done); end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        hang = 1'b1;
        do_start(PA, 32'd1, 32'd1, {256{1'b1}});
        while (!timeout_err && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (cyc !== TIMEOUT + 2) begin n_fail++; $display("FAIL t4_cycles: got %0d want %0d", cyc, TIMEOUT + 2); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t4_done: got %b want 1", done); end
        n_tests++; if (found !== 1'b0) begin n_fail++; $display("FAIL t4_found: got %b want 0", found); end
        hang = 1'b0;
        repeat (2) @(negedge clk);
        do_start(PA, 32'd1, 32'd1, {256{1'b1}});
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL t4_clear: got %b want 0", timeout_err); end
        wait_done(5000);
        n_tests++; if (found !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL t4_rerun: found=%b tmo=%b want 1/0", found, timeout_err);
        end
    endtask

    task automatic test_abort_stale();
        int b0 = n_begin;
        int cyc = 0;
        do_start(PA, 32'd2, 32'd2, {256{1'b1}});
        wait_begins(b0, 2);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t5_done: got %b want 1", done); end
        n_tests++; if (found !== 1'b0) begin n_fail++; $display("FAIL t5_found: got %b want 0", found); end
        while (!sha_complete && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        // start and abort together while idle must do nothing
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle_abort: busy=%b want 0", busy); end
        do_start(PA, 32'd9, 32'd9, {256{1'b1}});
        wait_done(5000);
        n_tests++; if (golden_nonce !== 32'd9) begin n_fail++; $display("FAIL t5_gnonce: got %h want 9", golden_nonce); end
        n_tests++; if (last_msg2 !== {184'd0, P1PAT, 32'd9}) begin n_fail++; $display("FAIL t5_msg2: got %h", last_msg2); end
    endtask

    task automatic test_reset_and_busy_start();
        int b0 = n_begin;
        do_start(PA, 32'd20, 32'd20, {256{1'b1}});
        wait_begins(b0, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0) begin
            n_fail++; $display("FAIL t6_flags: busy=%b done=%b found=%b want 0", busy, done, found);
        end
        n_tests++; if (sha_msg !== '0 || sha_len !== '0) begin n_fail++; $display("FAIL t6_msg: got %h len %h want 0", sha_msg, sha_len); end
        n_tests++; if (cur_nonce !== '0 || golden_nonce !== '0) begin
            n_fail++; $display("FAIL t6_nonce: cur=%h golden=%h want 0", cur_nonce, golden_nonce);
        end
        n_tests++; if (golden_hash !== '0) begin n_fail++; $display("FAIL t6_ghash: got %h want 0", golden_hash); end
        b0 = n_begin;
        do_start(PA, 32'd20, 32'd20, {256{1'b1}});
        wait_begins(b0, 1);
        repeat (5) @(negedge clk);
        do_start(PB, 32'd99, 32'd99, '0);
        n_tests++; if (sha_msg !== pk(PA, 32'd20)) begin n_fail++; $display("FAIL t6_busy_msg: got %h", sha_msg); end
        n_tests++; if (cur_nonce !== 32'd20 || busy !== 1'b1) begin
            n_fail++; $display("FAIL t6_busy_state: cur=%h busy=%b want 20/1", cur_nonce, busy);
        end
        wait_done(5000);
        n_tests++; if (found !== 1'b1 || golden_nonce !== 32'd20) begin
            n_fail++; $display("FAIL t6_result: found=%b golden=%h want 1/20", found, golden_nonce);
        end
    endtask

    initial begin
        test_reset();
        test_single_nonce();
        test_hit_mid_range();
        test_wrap_no_hit();
        test_timeout();
        test_abort_stale();
        test_reset_and_busy_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
